alu_pipe_mul: RTL and testbench

//  Registered, parametrised Hack-style ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pipe_mul.sv | 115 +++++++++++
 tb/tb_alu_pipe_mul.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_mul.sv
// rtl/alu_pipe_mul.sv - Registered Hack ALU with iterative shift-add multiply and valid/ready handshakes
module alu_pipe_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    input  logic             mul_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             busy
);
    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   out_q;
    logic               out_valid_q;
    logic               zr_q;
    logic               ng_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   xa, xb, ya, yb, fr;
    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   acc_d;
    logic               accept;

    always_comb begin
        xa    = ctrl[5] ? '0 : x;
        xb    = ctrl[4] ? ~xa : xa;
        ya    = ctrl[3] ? '0 : y;
        yb    = ctrl[2] ? ~ya : ya;
        fr    = ctrl[1] ? (xb + yb) : (xb & yb);
        res_d = ctrl[0] ? ~fr : fr;
    end

    always_comb begin
        acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // The output slot must be empty or draining this cycle before any new command enters.
    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign busy      = (state_q == MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (mul_en) begin
                            state_q  <= MUL;
                            mcand_q  <= x;
                            mplier_q <= y;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            out_q       <= res_d;
                            zr_q        <= (res_d == '0);
                            ng_q        <= res_d[WIDTH-1];
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q     <= IDLE;
                        out_q       <= acc_d;
                        zr_q        <= (acc_d == '0);
                        ng_q        <= acc_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe_mul.sv
// tb/tb_alu_pipe_mul.sv - Self-checking bench for alu_pipe_mul with directed steps and a random scoreboard stream
module tb_alu_pipe_mul;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  ctrl;
    logic        mul_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        zr;
    logic        ng;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    alu_pipe_mul #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .ctrl      (ctrl),
        .mul_en    (mul_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .zr        (zr),
        .ng        (ng),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hack_ref(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] xv, yv, f;
        xv = c[5] ? 16'h0 : a;
        if (c[4]) xv = ~xv;
        yv = c[3] ? 16'h0 : b;
        if (c[2]) yv = ~yv;
        f = c[1] ? (xv + yv) : (xv & yv);
        return c[0] ? ~f : f;
    endfunction

    function automatic logic [15:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        return p[15:0];
    endfunction

    task automatic hack_step(input string tag, input logic [5:0] c, input logic [15:0] xv, input logic [15:0] yv);
        logic [15:0] e;
        e = hack_ref(c, xv, yv);
        @(negedge clk);
        in_valid = 1'b1; mul_en = 1'b0; ctrl = c; x = xv; y = yv; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_out"}, 32'(dout), 32'(e));
        check({tag, "_zr"}, 32'(zr), 32'(e == 16'h0));
        check({tag, "_ng"}, 32'(ng), 32'(e[15]));
        check({tag, "_valid"}, 32'(out_valid), 1);
    endtask

    logic [15:0] sb_q[$];
    logic [15:0] e_out;
    logic [15:0] held_out;
    logic        held;
    int          accepted;
    int          cycles;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; ctrl = '0; mul_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out", 32'(dout), 0);
        check("rst_zr", 32'(zr), 0);
        check("rst_ng", 32'(ng), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        hack_step("add", 6'b000010, 16'd5, 16'd7);
        hack_step("x_minus_y", 6'b010011, 16'd3, 16'd5);
        hack_step("zero", 6'b101010, 16'h1234, 16'h5678);
        hack_step("not_x", 6'b001101, 16'h00F0, 16'hAAAA);

        // Multiply 300*300 and hold the result for the backpressure step.
        @(negedge clk);
        in_valid = 1'b1; mul_en = 1'b1; x = 16'd300; y = 16'd300; out_ready = 1'b1;
        #1 check("mul_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0; mul_en = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("mul_busy", 32'(busy), 1);
            check("mul_in_ready_low", 32'(in_ready), 0);
            check("mul_no_valid", 32'(out_valid), 0);
            @(negedge clk);
        end
        check("mul_valid", 32'(out_valid), 1);
        check("mul_out", 32'(dout), 32'd24464);
        check("mul_busy_done", 32'(busy), 0);

        in_valid = 1'b1; mul_en = 1'b0; ctrl = 6'b001100; x = 16'd9; y = 16'h7777;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_hold", 32'(dout), 32'd24464);
            check("bp_valid_hold", 32'(out_valid), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("b2b_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_out", 32'(dout), 9);
        check("b2b_valid", 32'(out_valid), 1);

        // Reset eight cycles into a multiply.
        in_valid = 1'b1; mul_en = 1'b1; x = 16'h1357; y = 16'h2468;
        @(negedge clk);
        in_valid = 1'b0; mul_en = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_out", 32'(dout), 0);
        check("mid_rst_zr", 32'(zr), 0);
        check("mid_rst_ng", 32'(ng), 0);
        check("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_in_ready", 32'(in_ready), 1);
        repeat (20) @(negedge clk);
        check("rel_no_stale_valid", 32'(out_valid), 0);
        check("rel_busy", 32'(busy), 0);

        // Random stream against an in-order scoreboard.
        accepted = 0; cycles = 0; held = 1'b0; held_out = '0;
        while (cycles < 20000 && (accepted < 100 || sb_q.size() != 0)) begin
            @(negedge clk);
            cycles++;
            in_valid  = (accepted < 100) && ($urandom_range(0, 9) < 7);
            mul_en    = ($urandom_range(0, 7) == 0);
            ctrl      = 6'($urandom);
            x         = 16'($urandom);
            y         = 16'($urandom);
            out_ready = (accepted >= 100) || ($urandom_range(0, 2) != 0);
            #1;
            if (held) begin
                check("rnd_hold_valid", 32'(out_valid), 1);
                check("rnd_hold_out", 32'(dout), 32'(held_out));
            end
            if (out_valid && out_ready) begin
                check("rnd_sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e_out = sb_q.pop_front();
                    check("rnd_out", 32'(dout), 32'(e_out));
                    check("rnd_zr", 32'(zr), 32'(e_out == 16'h0));
                    check("rnd_ng", 32'(ng), 32'(e_out[15]));
                end
            end
            held     = out_valid && !out_ready;
            held_out = dout;
            if (in_valid && in_ready) begin
                sb_q.push_back(mul_en ? mul_ref(x, y) : hack_ref(ctrl, x, y));
                accepted++;
            end
        end
        in_valid = 1'b0;
        check("rnd_accepted", 32'(accepted), 100);
        check("rnd_drained", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
